// File: rtl/shortest_path_reader.sv
`default_nettype none
// ============================================================================
//  Module      : shortest_path_reader
//  Description : Walks the predecessor chain left in the distance/predecessor
//                memory, from the destination back to the source. It streams
//                each vertex on a valid/ready port, then reports the path
//                cost, the hop count and a completion status.
//  Revision    : 1.0 - initial release
// ============================================================================
module shortest_path_reader #(
   parameter int          ADDR_W  = 13,
   parameter int          DATA_W  = 128,
   parameter logic [31:0] INF_VAL = 32'h0001_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        source_num,
   input  logic [7:0]        destination,
   input  logic [7:0]        vertice_num,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        path_vertex,
   output logic              path_valid,
   input  logic              path_ready,
   output logic              path_last,
   output logic [31:0]       path_cost,
   output logic [7:0]        hop_count,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] C_ST_OK    = 2'b00;
   localparam logic [1:0] C_ST_UNRCH = 2'b01;
   localparam logic [1:0] C_ST_LOOP  = 2'b10;
   localparam logic [1:0] C_ST_BAD   = 2'b11;

   state_t              state_q, state_d;
   logic [7:0]          src_q, src_d;
   logic [7:0]          n_q, n_d;
   logic [7:0]          cur_v_q, cur_v_d;
   logic [7:0]          pred_q, pred_d;
   logic                mem_re_q, mem_re_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          path_vertex_q, path_vertex_d;
   logic                path_valid_q, path_valid_d;
   logic                path_last_q, path_last_d;
   logic [31:0]         path_cost_q, path_cost_d;
   logic [7:0]          hop_count_q, hop_count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [1:0]          status_q, status_d;

   logic [31:0]         w_dist;
   logic [7:0]          w_pred;
   logic                w_bad_arg;
   logic                unused_rdata;

   assign w_dist       = mem_rdata[95:64];
   assign w_pred       = mem_rdata[7:0];
   assign unused_rdata = ^{mem_rdata[DATA_W-1:96], mem_rdata[63:8]};

   assign w_bad_arg = (source_num == 8'd0) || (destination == 8'd0) ||
                      (vertice_num == 8'd0) ||
                      (source_num > vertice_num) || (destination > vertice_num);

   // State and registered outputs; reset aborts any walk without a done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         src_q         <= '0;
         n_q           <= '0;
         cur_v_q       <= '0;
         pred_q        <= '0;
         mem_re_q      <= 1'b0;
         mem_addr_q    <= '0;
         path_vertex_q <= '0;
         path_valid_q  <= 1'b0;
         path_last_q   <= 1'b0;
         path_cost_q   <= '0;
         hop_count_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         status_q      <= '0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         n_q           <= n_d;
         cur_v_q       <= cur_v_d;
         pred_q        <= pred_d;
         mem_re_q      <= mem_re_d;
         mem_addr_q    <= mem_addr_d;
         path_vertex_q <= path_vertex_d;
         path_valid_q  <= path_valid_d;
         path_last_q   <= path_last_d;
         path_cost_q   <= path_cost_d;
         hop_count_q   <= hop_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         status_q      <= status_d;
      end
   end

   // Next state plus next values of every output. Outputs are set up one
   // cycle early, so each one is a flop that is valid in its own state.
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      n_d           = n_q;
      cur_v_d       = cur_v_q;
      pred_d        = pred_q;
      mem_re_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      path_vertex_d = path_vertex_q;
      path_valid_d  = path_valid_q;
      path_last_d   = path_last_q;
      path_cost_d   = path_cost_q;
      hop_count_d   = hop_count_q;
      status_d      = status_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d       = source_num;
               n_d         = vertice_num;
               hop_count_d = '0;
               path_cost_d = '0;
               status_d    = C_ST_OK;
               if (w_bad_arg) begin
                  state_d  = S_DONE;
                  status_d = C_ST_BAD;
               end else begin
                  cur_v_d    = destination;
                  state_d    = S_RD;
                  mem_re_d   = 1'b1;
                  mem_addr_d = {{(ADDR_W-8){1'b0}}, destination};
               end
            end
         end
         S_RD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            pred_d = w_pred;
            if (w_dist == INF_VAL) begin
               state_d  = S_DONE;
               status_d = C_ST_UNRCH;
            end else begin
               // The path cost is the distance stored at the destination.
               if (hop_count_q == 8'd0) begin
                  path_cost_d = w_dist;
               end
               state_d       = S_EMIT;
               path_valid_d  = 1'b1;
               path_vertex_d = cur_v_q;
               path_last_d   = (cur_v_q == src_q);
            end
         end
         S_EMIT: begin
            if (path_valid_q && path_ready) begin
               hop_count_d  = hop_count_q + 8'd1;
               path_valid_d = 1'b0;
               path_last_d  = 1'b0;
               if (path_last_q) begin
                  state_d  = S_DONE;
                  status_d = C_ST_OK;
               end else if (({1'b0, hop_count_q} + 9'd1) == {1'b0, n_q}) begin
                  // N beats without reaching the source means the chain loops.
                  state_d  = S_DONE;
                  status_d = C_ST_LOOP;
               end else begin
                  cur_v_d    = pred_q;
                  state_d    = S_RD;
                  mem_re_d   = 1'b1;
                  mem_addr_d = {{(ADDR_W-8){1'b0}}, pred_q};
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   assign mem_re      = mem_re_q;
   assign mem_addr    = mem_addr_q;
   assign path_vertex = path_vertex_q;
   assign path_valid  = path_valid_q;
   assign path_last   = path_last_q;
   assign path_cost   = path_cost_q;
   assign hop_count   = hop_count_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign status      = status_q;

endmodule
`default_nettype wire

// File: tb/tb_shortest_path_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shortest_path_reader
//  Description : Self-checking bench for shortest_path_reader. It uses a
//                table of directed walks, random graphs checked against a
//                path-walking reference model, and a reset-abort sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shortest_path_reader;

   localparam logic [31:0] INF = 32'h0001_0000;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   source_num = '0;
   logic [7:0]   destination = '0;
   logic [7:0]   vertice_num = '0;
   logic         mem_re;
   logic [12:0]  mem_addr;
   logic [127:0] mem_rdata = '0;
   logic [7:0]   path_vertex;
   logic         path_valid;
   logic         path_ready = 1'b1;
   logic         path_last;
   logic [31:0]  path_cost;
   logic [7:0]   hop_count;
   logic         busy;
   logic         done;
   logic [1:0]   status;

   shortest_path_reader dut (
      .clock(clock), .reset(reset), .start(start),
      .source_num(source_num), .destination(destination), .vertice_num(vertice_num),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .path_vertex(path_vertex), .path_valid(path_valid), .path_ready(path_ready),
      .path_last(path_last), .path_cost(path_cost), .hop_count(hop_count),
      .busy(busy), .done(done), .status(status)
   );

   always #5 clock = ~clock;

   // Result memory: the read word appears the cycle after the strobe.
   logic [31:0] dist_mem [256];
   logic [7:0]  pred_mem [256];
   always @(posedge clock) begin
      if (mem_re) mem_rdata <= {32'h0, dist_mem[mem_addr[7:0]], 56'h0, pred_mem[mem_addr[7:0]]};
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Observed and expected walk results
   logic [7:0] got_v[$];
   bit         got_l[$];
   int         got_mem_re, got_first_valid, got_done_cyc;
   logic [7:0] exp_v[$];
   bit         exp_l[$];
   logic [1:0] exp_st;
   int         exp_hops;
   logic [31:0] exp_cost;

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         dist_mem[i] = 32'd0;
         pred_mem[i] = 8'd0;
      end
   endtask

   task automatic load_graph(input int g);
      clear_mem();
      case (g)
         0: begin pred_mem[4] = 2; pred_mem[2] = 1; dist_mem[4] = 7; dist_mem[2] = 4; end
         1: begin dist_mem[4] = INF; end
         2: begin pred_mem[4] = 3; pred_mem[3] = 4; dist_mem[4] = 9; dist_mem[3] = 2; end
         3: begin pred_mem[4] = 2; dist_mem[4] = 7; dist_mem[2] = INF; end
         default: ;
      endcase
   endtask

   // Reference: follow predecessor pointers from the destination.
   task automatic model(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
      logic [7:0] v;
      exp_v.delete(); exp_l.delete();
      exp_st = 2'd0; exp_hops = 0; exp_cost = 32'd0;
      if (s == 0 || d == 0 || n == 0 || s > n || d > n) begin
         exp_st = 2'd3;
         return;
      end
      v = d;
      for (int k = 0; k < 300; k++) begin
         if (dist_mem[v] == INF) begin exp_st = 2'd1; return; end
         if (exp_hops == 0) exp_cost = dist_mem[v];
         exp_v.push_back(v);
         exp_l.push_back(v == s);
         exp_hops++;
         if (v == s) begin exp_st = 2'd0; return; end
         if (exp_hops == int'(n)) begin exp_st = 2'd2; return; end
         v = pred_mem[v];
      end
   endtask

   // rmode: 0 ready high, 1 random ready, 2 stall 5 cycles on beat 2, 3 start while busy
   task automatic run_walk(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n, input int rmode);
      int         stall;
      bit         prev_hold;
      logic [7:0] prev_vtx;
      stall = 0; prev_hold = 0; prev_vtx = '0;
      got_v.delete(); got_l.delete();
      got_mem_re = 0; got_first_valid = -1; got_done_cyc = -1;
      @(negedge clock);
      source_num = s; destination = d; vertice_num = n; start = 1'b1; path_ready = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clock);
         if (cyc == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, 1);
         end
         if (rmode == 3 && cyc == 4) begin start = 1'b1; source_num = 3; destination = 3; end
         if (rmode == 3 && cyc == 5) start = 1'b0;
         case (rmode)
            1: path_ready = ($urandom_range(0, 2) != 0);
            2: begin
               if (path_valid && got_v.size() == 1 && stall < 5) begin
                  path_ready = 1'b0;
                  stall++;
               end else path_ready = 1'b1;
            end
            default: path_ready = 1'b1;
         endcase
         if (mem_re) got_mem_re++;
         if (path_valid && got_first_valid < 0) got_first_valid = cyc;
         if (prev_hold) begin
            chk("held_valid", path_valid, 1);
            chk("held_vertex", path_vertex, prev_vtx);
         end
         prev_hold = path_valid && !path_ready;
         prev_vtx  = path_vertex;
         if (path_valid && path_ready) begin
            got_v.push_back(path_vertex);
            got_l.push_back(path_last);
         end
         if (done) begin
            got_done_cyc = cyc;
            @(negedge clock);
            chk("done_width", done, 0);
            chk("busy_after_done", busy, 0);
            path_ready = 1'b1;
            return;
         end
      end
      chk("walk_timeout", 1, 0);
   endtask

   task automatic compare(input string tag, input int exp_done_cyc, input int exp_mem_re);
      chk({tag, "_status"}, status, exp_st);
      chk({tag, "_hops"}, hop_count, exp_hops);
      chk({tag, "_cost"}, path_cost, exp_cost);
      chk({tag, "_nbeats"}, got_v.size(), exp_v.size());
      for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
         chk({tag, "_beat_vertex"}, got_v[i], exp_v[i]);
         chk({tag, "_beat_last"}, got_l[i], exp_l[i]);
      end
      chk({tag, "_first_valid_cyc"}, got_first_valid, (exp_v.size() > 0) ? 3 : -1);
      chk({tag, "_mem_re_count"}, got_mem_re, exp_mem_re);
      if (exp_done_cyc >= 0) chk({tag, "_done_cyc"}, got_done_cyc, exp_done_cyc);
   endtask

   typedef struct {
      string      name;
      int         graph;
      logic [7:0] src, dst, n;
      int         rmode;
      logic [1:0] st;
      int         hops;
      logic [31:0] cost;
      int         nbeats;
      logic [7:0] b [4];
      int         done_cyc;
      int         nreads;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{"path",      0, 1, 4, 4, 0, 2'd0, 3, 7, 3, '{4, 2, 1, 0}, 10, 3};
      vecs[1] = '{"same",      0, 3, 3, 4, 0, 2'd0, 1, 0, 1, '{3, 0, 0, 0},  4, 1};
      vecs[2] = '{"inf_first", 1, 1, 4, 4, 0, 2'd1, 0, 0, 0, '{0, 0, 0, 0},  3, 1};
      vecs[3] = '{"loop",      2, 1, 4, 4, 0, 2'd2, 4, 9, 4, '{4, 3, 4, 3}, 13, 4};
      vecs[4] = '{"dst_zero",  0, 1, 0, 8, 0, 2'd3, 0, 0, 0, '{0, 0, 0, 0},  1, 0};
      vecs[5] = '{"dst_big",   0, 1, 9, 8, 0, 2'd3, 0, 0, 0, '{0, 0, 0, 0},  1, 0};
      vecs[6] = '{"n_zero",    0, 1, 1, 0, 0, 2'd3, 0, 0, 0, '{0, 0, 0, 0},  1, 0};
      vecs[7] = '{"inf_mid",   3, 1, 4, 4, 0, 2'd1, 1, 7, 1, '{4, 0, 0, 0},  6, 2};
      vecs[8] = '{"stall",     0, 1, 4, 4, 2, 2'd0, 3, 7, 3, '{4, 2, 1, 0}, 15, 3};
      vecs[9] = '{"busy_start",0, 1, 4, 4, 3, 2'd0, 3, 7, 3, '{4, 2, 1, 0}, 10, 3};

      clear_mem();
      repeat (2) @(negedge clock);
      chk("reset_outputs", |{mem_re, mem_addr, path_vertex, path_valid, path_last,
                             path_cost, hop_count, busy, done, status}, 0);
      reset = 1'b1;

      // Directed table
      for (int t = 0; t < 10; t++) begin
         load_graph(vecs[t].graph);
         exp_v.delete(); exp_l.delete();
         for (int i = 0; i < vecs[t].nbeats; i++) begin
            exp_v.push_back(vecs[t].b[i]);
            exp_l.push_back((i == vecs[t].nbeats - 1) && (vecs[t].st == 2'd0));
         end
         exp_st = vecs[t].st; exp_hops = vecs[t].hops; exp_cost = vecs[t].cost;
         run_walk(vecs[t].src, vecs[t].dst, vecs[t].n, vecs[t].rmode);
         compare(vecs[t].name, vecs[t].done_cyc, vecs[t].nreads);
      end

      // Reset during EMIT: outputs clear immediately, then a clean walk follows
      load_graph(0);
      @(negedge clock);
      source_num = 1; destination = 4; vertice_num = 4; start = 1'b1; path_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 20 && !path_valid; k++) @(negedge clock);
      chk("rst_reached_emit", path_valid, 1);
      reset = 1'b0;
      #1;
      chk("rst_mid_outputs", |{mem_re, mem_addr, path_vertex, path_valid, path_last,
                               path_cost, hop_count, busy, done, status}, 0);
      @(negedge clock);
      chk("rst_next_outputs", |{mem_re, path_valid, busy, done, status, hop_count}, 0);
      reset = 1'b1;
      path_ready = 1'b1;
      model(1, 4, 4);
      run_walk(1, 4, 4, 0);
      compare("after_reset", 10, 3);

      // Random graphs against the reference walk
      for (int r = 0; r < 40; r++) begin
         logic [7:0] n, s, d;
         n = 8'($urandom_range(1, 8));
         for (int v = 0; v < 256; v++) begin
            dist_mem[v] = ($urandom_range(0, 7) == 0) ? INF : 32'($urandom_range(0, 99));
            pred_mem[v] = 8'($urandom_range(0, int'(n) + 1));
         end
         s = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(1, int'(n)));
         d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(1, int'(n)));
         model(s, d, n);
         run_walk(s, d, n, 1);
         compare("random", -1, exp_v.size() + ((exp_st == 2'd1) ? 1 : 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
